// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   arb_state_t : ownership FSM encoding (IDLE / OWN0 / OWN1)
//   PORT_CPU    : index of the CPU data port (port 0)
//   PORT_DBG    : index of the loader/debug port (port 1)
//   DEF_*       : default data width, byte-address width and memory depth
//   own_state() : maps a port index to its locked-owner state
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 32;
  localparam int DEF_DEPTH = 64;

  function automatic arb_state_t own_state(input logic port);
    return (port == 1'(PORT_DBG)) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Combinational winner selection for the two-port data-memory arbiter.
//   req[1:0] : request from port 1 / port 0
//   state    : current ownership state
//   last     : port granted most recently (only present when
//              DMEM_ARB_RR_EN is defined)
//   win      : index of the selected port; 0 when nobody requests so the
//              memory address/data default to port 0
//   win_vld  : the selected port is actually requesting this cycle
// Optional feature macro: DMEM_ARB_RR_EN (round-robin on contention instead
// of fixed priority to port 0).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_state_t state,
`ifdef DMEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic       win,
  output logic       win_vld
);

  always_comb begin
    win     = 1'(PORT_CPU);
    win_vld = 1'b0;
    unique case (state)
      ST_IDLE: begin
        win_vld = |req;
        if (req == 2'b10) begin
          win = 1'(PORT_DBG);
        end else if (req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
          // Contention: hand the memory to whoever did not have it last.
          win = ~last;
`else
          win = 1'(PORT_CPU);
`endif
        end
      end
      // A locked owner is the only candidate; the other port waits even if
      // the owner is momentarily not requesting.
      ST_OWN0: begin
        win     = 1'(PORT_CPU);
        win_vld = req[0];
      end
      ST_OWN1: begin
        win     = 1'(PORT_DBG);
        win_vld = req[1];
      end
      default: begin
        win     = 1'(PORT_CPU);
        win_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU data port (port 0) and
// the loader/debug port (port 1). At most one port is granted per cycle; the
// granted port drives the memory address, write data and write enable.
// Read data returns registered one cycle after the grant. A port may keep
// ownership across accesses with its lock input.
//
// Handshake (both ports): a port raises req with we/addr/wd/lock stable and
// holds them until gnt=1. gnt is combinational and the access completes in
// the cycle gnt=1 (write commits at the closing posedge; read data appears
// with rvalid=1 on the following cycle). rvalid/err are single-cycle pulses
// with no back-pressure.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   mN_req/we/lock/addr/wd  : request side of port N
//   mN_gnt                  : access accepted this cycle
//   mN_rvalid/mN_rdata      : registered read return
//   mN_err                  : registered pulse for an out-of-range access
//   mem_we/mem_a/mem_wd     : drive to dmem
//   mem_rd                  : combinational read data from dmem
//   dbg_state               : current ownership FSM state
// Optional feature macro: DMEM_ARB_RR_EN (round-robin contention policy).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,

  output arb_state_t    dbg_state
);

  // Word-index limit, sized to the word-index field of the address.
  localparam logic [AW-3:0] DEPTH_IDX = (AW-2)'(DEPTH);

  arb_state_t state_q, state_d;
  logic       win, win_vld, granted;
  logic       m0_inr, m1_inr;
  logic       sel_we, sel_lock, sel_inr;

`ifdef DMEM_ARB_RR_EN
  logic       last_q;
`endif

  dmem_arb_pick u_pick (
    .req     ({m1_req, m0_req}),
    .state   (state_q),
`ifdef DMEM_ARB_RR_EN
    .last    (last_q),
`endif
    .win     (win),
    .win_vld (win_vld)
  );

  assign m0_inr = (m0_addr[AW-1:2] < DEPTH_IDX);
  assign m1_inr = (m1_addr[AW-1:2] < DEPTH_IDX);

  // No grant (and therefore no memory write) while reset is held.
  assign granted = win_vld & ~reset;
  assign m0_gnt  = granted & (win == 1'(PORT_CPU));
  assign m1_gnt  = granted & (win == 1'(PORT_DBG));

  assign sel_we   = win ? m1_we   : m0_we;
  assign sel_lock = win ? m1_lock : m0_lock;
  assign sel_inr  = win ? m1_inr  : m0_inr;

  // win is 0 when idle, so port 0 owns the address/data bus by default.
  assign mem_a  = win ? m1_addr : m0_addr;
  assign mem_wd = win ? m1_wd   : m0_wd;
  // Out-of-range writes are still granted but never reach the memory.
  assign mem_we = granted & sel_we & sel_inr;

  assign dbg_state = state_q;

  // Ownership FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (granted && sel_lock) begin
          state_d = own_state(win);
        end
      end
      // The owner releases either with an unlocked access or by dropping req.
      ST_OWN0: begin
        if (!m0_req || (m0_gnt && !m0_lock)) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_req || (m1_gnt && !m1_lock)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DMEM_ARB_RR_EN
  // Starts at port 1 so that port 0 wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'(PORT_DBG);
    end else if (granted) begin
      last_q <= win;
    end
  end
`endif

  // Read return and error pulses. rdata is only updated by a granted read;
  // out-of-range reads return zero rather than the aliased memory word.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      m0_err    <= m0_gnt & ~m0_inr;
      m1_err    <= m1_gnt & ~m1_inr;
      if (m0_gnt && !m0_we) begin
        m0_rdata <= m0_inr ? mem_rd : '0;
      end
      if (m1_gnt && !m1_we) begin
        m1_rdata <= m1_inr ? mem_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 64-word dmem attached.
// The memory is preloaded with word i = 0xA000_0000 + i while reset is held.
module tb_dmem_arbiter
  import dmem_arb_pkg::*;
;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic fill;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wd, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wd, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  arb_state_t  dbg_state;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wd     (m0_wd),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wd     (m1_wd),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] dmem [0:63];

  assign mem_rd = dmem[mem_a[7:2]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_we) begin
      dmem[mem_a[7:2]] <= mem_wd;
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = 32'hxxxx_xxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, got, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wd = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wd = wd;
  endtask

  // ---------------- stimulus ----------------
  logic exp_w;

  initial begin
    reset = 1'b1;
    fill  = 1'b1;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step();
    step();

    // Reset state; a write request during reset must not be granted.
    drive0(1, 1, 0, 32'h8, 32'h5555_5555);
    @(negedge clk);
    chk("rst_gnt0",   32'(m0_gnt),    32'd0);
    chk("rst_gnt1",   32'(m1_gnt),    32'd0);
    chk("rst_memwe",  32'(mem_we),    32'd0);
    chk("rst_rv0",    32'(m0_rvalid), 32'd0);
    chk("rst_rv1",    32'(m1_rvalid), 32'd0);
    chk("rst_err0",   32'(m0_err),    32'd0);
    chk("rst_err1",   32'(m1_err),    32'd0);
    chk("rst_rdata0", m0_rdata,       32'd0);
    chk("rst_rdata1", m1_rdata,       32'd0);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    step();
    reset = 1'b0;
    fill  = 1'b0;
    drive0(0, 0, 0, 0, 0);

    // Contention: both ports read for four cycles.
    drive0(1, 0, 0, 32'h8, 0);
    drive1(1, 0, 0, 32'hC, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      exp_w = k[0];
`else
      exp_w = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("cont_gnt0_%0d", k), 32'(m0_gnt), 32'(!exp_w));
      chk($sformatf("cont_gnt1_%0d", k), 32'(m1_gnt), 32'(exp_w));
      exp_q.push_back(exp_w ? 32'hA000_0003 : 32'hA000_0002);
      step();
      chk($sformatf("cont_rv0_%0d", k), 32'(m0_rvalid), 32'(!exp_w));
      chk($sformatf("cont_rv1_%0d", k), 32'(m1_rvalid), 32'(exp_w));
      check_rd($sformatf("cont_rd_%0d", k), exp_w ? m1_rdata : m0_rdata);
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);

    // Uncontended write then read-back.
    drive0(1, 1, 0, 32'h8, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_gnt0",  32'(m0_gnt), 32'd1);
    chk("wr_memwe", 32'(mem_we), 32'd1);
    chk("wr_mema",  mem_a,       32'h8);
    chk("wr_memwd", mem_wd,      32'hDEAD_BEEF);
    step();
    chk("wr_rv0", 32'(m0_rvalid), 32'd0);
    drive0(1, 0, 0, 32'h8, 0);
    @(negedge clk);
    chk("rd_gnt0",  32'(m0_gnt), 32'd1);
    chk("rd_memwe", 32'(mem_we), 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    chk("rd_rv0", 32'(m0_rvalid), 32'd1);
    chk("rd_rv1", 32'(m1_rvalid), 32'd0);
    check_rd("rd_data0", m0_rdata);
    drive0(0, 0, 0, 0, 0);

    // Lock: port 1 writes three words, port 0 waits.
    drive1(1, 1, 1, 32'h0, 32'h0000_0011);
    @(negedge clk);
    chk("lk_gnt1_a",  32'(m1_gnt), 32'd1);
    chk("lk_memwe_a", 32'(mem_we), 32'd1);
    step();
    chk("lk_state_a", 32'(dbg_state), 32'(ST_OWN1));
    drive0(1, 0, 0, 32'h10, 0);
    drive1(1, 1, 1, 32'h4, 32'h0000_0022);
    @(negedge clk);
    chk("lk_gnt0_b", 32'(m0_gnt), 32'd0);
    chk("lk_gnt1_b", 32'(m1_gnt), 32'd1);
    step();
    drive1(1, 1, 0, 32'h8, 32'h0000_0033);
    @(negedge clk);
    chk("lk_gnt0_c", 32'(m0_gnt), 32'd0);
    chk("lk_gnt1_c", 32'(m1_gnt), 32'd1);
    step();
    chk("lk_state_c", 32'(dbg_state), 32'(ST_IDLE));
    drive1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_gnt0_d", 32'(m0_gnt), 32'd1);
    exp_q.push_back(32'hA000_0004);
    step();
    chk("lk_rv0_d", 32'(m0_rvalid), 32'd1);
    check_rd("lk_rd0_d", m0_rdata);
    drive0(0, 0, 0, 0, 0);
    drive1(1, 0, 0, 32'h4, 0);
    @(negedge clk);
    exp_q.push_back(32'h0000_0022);
    step();
    check_rd("lk_rd1_w4", m1_rdata);
    drive1(1, 0, 0, 32'h8, 0);
    @(negedge clk);
    exp_q.push_back(32'h0000_0033);
    step();
    check_rd("lk_rd1_w8", m1_rdata);
    drive1(0, 0, 0, 0, 0);

    // Release without access: port 0 locks, then drops req.
    drive0(1, 0, 1, 32'h10, 0);
    @(negedge clk);
    chk("rel_gnt0", 32'(m0_gnt), 32'd1);
    exp_q.push_back(32'hA000_0004);
    step();
    chk("rel_state_own", 32'(dbg_state), 32'(ST_OWN0));
    check_rd("rel_rd0", m0_rdata);
    drive0(0, 0, 0, 0, 0);
    drive1(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("rel_gnt1_blocked", 32'(m1_gnt), 32'd0);
    step();
    chk("rel_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("rel_rv1_none",   32'(m1_rvalid), 32'd0);
    @(negedge clk);
    chk("rel_gnt1", 32'(m1_gnt), 32'd1);
    exp_q.push_back(32'h0000_0011);
    step();
    check_rd("rel_rd1", m1_rdata);
    drive1(0, 0, 0, 0, 0);

    // Range boundary: last in-range word.
    drive0(1, 0, 0, 32'hFC, 0);
    @(negedge clk);
    exp_q.push_back(32'hA000_003F);
    step();
    chk("oor_last_err", 32'(m0_err), 32'd0);
    check_rd("oor_last_rd", m0_rdata);

    // Out-of-range write then read.
    drive0(1, 1, 0, 32'h100, 32'h1111_1111);
    @(negedge clk);
    chk("oor_wr_gnt0",  32'(m0_gnt), 32'd1);
    chk("oor_wr_memwe", 32'(mem_we), 32'd0);
    step();
    chk("oor_wr_err0", 32'(m0_err),    32'd1);
    chk("oor_wr_rv0",  32'(m0_rvalid), 32'd0);
    drive0(1, 0, 0, 32'h100, 0);
    @(negedge clk);
    chk("oor_rd_gnt0", 32'(m0_gnt), 32'd1);
    exp_q.push_back(32'h0000_0000);
    step();
    chk("oor_rd_rv0",  32'(m0_rvalid), 32'd1);
    chk("oor_rd_err0", 32'(m0_err),    32'd1);
    check_rd("oor_rd_data", m0_rdata);
    drive0(0, 0, 0, 0, 0);
    step();
    chk("oor_err0_clr", 32'(m0_err),    32'd0);
    chk("oor_rv0_clr",  32'(m0_rvalid), 32'd0);
    drive0(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    exp_q.push_back(32'h0000_0011);
    step();
    check_rd("oor_no_alias", m0_rdata);
    drive0(0, 0, 0, 0, 0);

    // Reset while port 1 holds a lock with a read granted the cycle before.
    drive1(1, 0, 1, 32'h4, 0);
    @(negedge clk);
    chk("rl_gnt1", 32'(m1_gnt), 32'd1);
    exp_q.push_back(32'h0000_0022);
    step();
    chk("rl_state_own", 32'(dbg_state), 32'(ST_OWN1));
    check_rd("rl_rd1", m1_rdata);
    reset = 1'b1;
    drive0(1, 0, 0, 32'h0, 0);
    drive1(1, 1, 1, 32'h4, 32'hBAD0_BAD0);
    @(negedge clk);
    chk("rl_gnt0_rst",  32'(m0_gnt), 32'd0);
    chk("rl_gnt1_rst",  32'(m1_gnt), 32'd0);
    chk("rl_memwe_rst", 32'(mem_we), 32'd0);
    step();
    chk("rl_rv1_clr",   32'(m1_rvalid), 32'd0);
    chk("rl_state_clr", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    drive1(1, 0, 0, 32'h4, 0);
    @(negedge clk);
    chk("rl_gnt0_first", 32'(m0_gnt), 32'd1);
    chk("rl_gnt1_wait",  32'(m1_gnt), 32'd0);
    exp_q.push_back(32'h0000_0011);
    step();
    check_rd("rl_rd0", m0_rdata);
    drive0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rl_gnt1_next", 32'(m1_gnt), 32'd1);
    exp_q.push_back(32'h0000_0022);
    step();
    check_rd("rl_rd1_nowrite", m1_rdata);
    drive1(0, 0, 0, 0, 0);
    step();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
